// File: rtl/mic_capture.sv
// Stereo capture master: drives bit clock / word select to a codec and
// deserializes its MSB-first, left-justified data into left/right frame pairs.
module mic_capture #(
  parameter logic [2:0] SAMPLE_PHASE = 3'd7,
  parameter int         DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  au_sysclk,
  output logic                  au_bck,
  output logic                  au_ws,
  input  logic                  au_data,
  output logic [DATA_WIDTH-1:0] frame_left,
  output logic [DATA_WIDTH-1:0] frame_right,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  input  logic                  ovr_clr
);

  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  strobe;
  logic                  right_done;
  logic                  load;
  logic [DATA_WIDTH-1:0] word;

  assign au_sysclk   = clk;
  assign au_bck      = cnt_q[2];
  assign au_ws       = cnt_q[7];
  assign frame_left  = left_q;
  assign frame_right = right_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;

  // The word including the bit sampled on this edge; only meaningful on strobe.
  assign word       = {shift_q, au_data};
  assign strobe     = en && (cnt_q[2:0] == SAMPLE_PHASE);
  assign right_done = strobe && (cnt_q[7:3] == 5'b01111);
  assign load       = strobe && (cnt_q[7:3] == 5'b11111);

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    right_hold_d = right_hold_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;

    // Disabling discards any partial frame so re-enable starts aligned.
    if (!en) begin
      cnt_d        = 8'h00;
      shift_d      = '0;
      right_hold_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (strobe)     shift_d      = word[DATA_WIDTH-2:0];
      if (right_done) right_hold_d = word;
    end

    // A load beats a coincident transfer: the new pair stays presented.
    if (load) begin
      left_d  = word;
      right_d = right_hold_q;
      valid_d = 1'b1;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    if (load && valid_q && !frame_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 8'h00;
      shift_q      <= '0;
      right_hold_q <= '0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      right_hold_q <= right_hold_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mic_capture.sv
// Directed bench for mic_capture with a behavioural codec shifting words MSB-first.
module tb_mic_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        au_sysclk, au_bck, au_ws;
  logic        au_data = 1'b0;
  logic [15:0] frame_left, frame_right;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        overrun;
  logic        ovr_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] cod_l = 16'h0000;
  logic [15:0] cod_r = 16'h0000;
  logic [15:0] cw;
  logic [7:0]  ccnt = 8'h00;
  logic [7:0]  nxt;

  logic        mon_on = 1'b0;
  logic [31:0] got[$];

  mic_capture #(.SAMPLE_PHASE(3'd7), .DATA_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .au_sysclk   (au_sysclk),
    .au_bck      (au_bck),
    .au_ws       (au_ws),
    .au_data     (au_data),
    .frame_left  (frame_left),
    .frame_right (frame_right),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  always #5 clk = ~clk;

  // Codec: tracks its own frame position and changes data on each bit-clock rise.
  always @(posedge clk) begin
    if (rst || !en) nxt = 8'h00;
    else            nxt = ccnt + 8'd1;
    ccnt = nxt;
    if (nxt[2:0] == 3'd4) begin
      cw      = nxt[7] ? cod_l : cod_r;
      au_data = cw[4'd15 - nxt[6:3]];
    end
  end

  // Transfer monitor, sampled just before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (mon_on && frame_valid && frame_ready) got.push_back({frame_left, frame_right});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_to(input logic [7:0] tgt);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ccnt == tgt) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("run_to_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_first_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    bit found = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (frame_valid) begin
        check({tag, "_lat"}, i, 256);
        check({tag, "_left"}, frame_left, l);
        check({tag, "_right"}, frame_right, r);
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int bad;
    // Reset state
    repeat (3) tick();
    check("rst_bck", au_bck, 0);
    check("rst_ws", au_ws, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_left", frame_left, 16'h0000);
    check("rst_right", frame_right, 16'h0000);
    check("rst_sysclk", au_sysclk, clk);
    rst = 1'b0;

    // First frame after enable
    cod_r = 16'hA5C3;
    cod_l = 16'h0F0F;
    frame_ready = 1'b1;
    en = 1'b1;
    expect_first_frame("f1", 16'h0F0F, 16'hA5C3);
    check("f1_ovr", overrun, 0);
    tick();
    check("f1_onecyc", frame_valid, 0);
    run_to(8'h84);
    check("bck_84", au_bck, 1);
    check("ws_84", au_ws, 1);
    run_to(8'h04);
    check("bck_04", au_bck, 1);
    check("ws_04", au_ws, 0);

    // Continuous frames, ready pulsed once per frame
    run_to(8'h00);
    cod_l = 16'h8000;
    cod_r = 16'h7FFF;
    tick();
    frame_ready = 1'b0;
    got.delete();
    mon_on = 1'b1;
    run_to(8'h00);
    cod_l = 16'hFFFF;
    cod_r = 16'h0001;
    run_to(8'h40);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("cont_clear", frame_valid, 0);
    run_to(8'h00);
    cod_l = 16'h1234;
    cod_r = 16'h5678;
    run_to(8'h40);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    mon_on = 1'b0;
    check("cont_count", got.size(), 2);
    if (got.size() == 2) begin
      check("cont_pair0", got[0], 32'h8000_7FFF);
      check("cont_pair1", got[1], 32'hFFFF_0001);
    end
    check("cont_ovr", overrun, 0);

    // Overrun
    run_to(8'h00);
    check("ovr_pend", frame_valid, 1);
    check("ovr_none", overrun, 0);
    cod_l = 16'hCAFE;
    cod_r = 16'hBEEF;
    run_to(8'h00);
    check("ovr_set", overrun, 1);
    check("ovr_left", frame_left, 16'hCAFE);
    check("ovr_right", frame_right, 16'hBEEF);
    cod_l = 16'h1111;
    cod_r = 16'h2222;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    run_to(8'hFF);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_setwins", overrun, 1);
    check("ovr3_left", frame_left, 16'h1111);
    check("ovr3_right", frame_right, 16'h2222);

    // Transfer coinciding with a load
    cod_l = 16'hABCD;
    cod_r = 16'hEF01;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr2", overrun, 0);
    run_to(8'hFF);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("coin_valid", frame_valid, 1);
    check("coin_left", frame_left, 16'hABCD);
    check("coin_right", frame_right, 16'hEF01);
    check("coin_ovr", overrun, 0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("coin_accept", frame_valid, 0);

    // Enable dropped mid-frame
    cod_l = 16'h3C3C;
    cod_r = 16'hC3C3;
    run_to(8'hC0);
    en = 1'b0;
    tick();
    bad = 0;
    repeat (40) begin
      if (au_bck || au_ws || frame_valid) bad++;
      tick();
    end
    check("dis_idle", bad, 0);
    cod_l = 16'h9696;
    cod_r = 16'h6969;
    en = 1'b1;
    expect_first_frame("reen", 16'h9696, 16'h6969);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;

    // Reset mid-frame
    cod_l = 16'h5A5A;
    cod_r = 16'hA5A5;
    run_to(8'h90);
    rst = 1'b1;
    tick();
    check("mrst_bck", au_bck, 0);
    check("mrst_ws", au_ws, 0);
    check("mrst_valid", frame_valid, 0);
    check("mrst_left", frame_left, 16'h0000);
    check("mrst_right", frame_right, 16'h0000);
    cod_l = 16'h7E81;
    cod_r = 16'h1818;
    rst = 1'b0;
    expect_first_frame("rst_re", 16'h7E81, 16'h1818);
    check("end_ovr", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
